// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Bundles the IF-stage issue request and the stall controls returned to the
//   pipeline, so the sequencer and its environment share one port.
//   Signals:
//     if_valid  IF holds an instruction ready to issue into ID/EX
//     if_rs1    source register 1 (index 0 = zero register, never a dependency)
//     if_rs2    source register 2
//     if_rd     destination register
//     if_we     instruction writes if_rd
//     if_multi  instruction is a multi-cycle ALU op
//     stall     hold the IF->ID latch
//     bubble    insert a NOP into EX this cycle (RAW stall)
//     ex_hold   EX keeps its contents (multi-cycle op in progress)
//   Modports: master = pipeline side (drives the request), slave = sequencer.
interface hazard_stall_ctrl_if #(
  parameter int RW = 5
);
  logic          if_valid;
  logic [RW-1:0] if_rs1;
  logic [RW-1:0] if_rs2;
  logic [RW-1:0] if_rd;
  logic          if_we;
  logic          if_multi;
  logic          stall;
  logic          bubble;
  logic          ex_hold;

  modport master (
    output if_valid, if_rs1, if_rs2, if_rd, if_we, if_multi,
    input  stall, bubble, ex_hold
  );

  modport slave (
    input  if_valid, if_rs1, if_rs2, if_rd, if_we, if_multi,
    output stall, bubble, ex_hold
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/bubble sequencer for a 5-stage in-order pipeline without forwarding.
//   It remembers which registers are still to be written by the instructions
//   in EX, MEM and WB, holds the IF->ID latch while an issuing instruction
//   reads one of them, and holds EX while a multi-cycle ALU op is busy.
//   Ports:
//     clk           clock, all state changes on the rising edge
//     rst           synchronous, active-high reset
//     bus           hazard_stall_ctrl_if.slave: issue request in, stall controls out
//     stall_cycles  saturating count of cycles with stall=1 since reset
//   Parameters:
//     RW         register-index width
//     MUL_LAT    EX occupancy of a multi-cycle op, in cycles (>=1)
//     WB_BYPASS  1: the regfile writes before it reads, so the WB entry never hazards
//     CW         width of stall_cycles
module hazard_stall_ctrl #(
  parameter int RW        = 5,
  parameter int MUL_LAT   = 4,
  parameter int WB_BYPASS = 1,
  parameter int CW        = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus,
  output logic [CW-1:0]       stall_cycles
);

  // Number of pending entries (EX, MEM[, WB]) that can block an issue.
  localparam int NCHK = (WB_BYPASS != 0) ? 2 : 3;
  // Busy counter only has to hold MUL_LAT-1.
  localparam int CNTW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'((MUL_LAT > 1) ? (MUL_LAT - 1) : 0);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    HAZ = 2'd1,
    MUL = 2'd2
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [2:0]      pend_valid;
  logic [RW-1:0]   pend_rd [3];

  logic hazard;
  logic ex_hold;
  logic stall;
  logic bubble;
  logic issue;

  // RAW check of the instruction waiting in IF against the pending writes.
  // Everything is forced low during reset so the pipeline sees no stall in
  // the reset cycle regardless of the stale state.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NCHK; i++) begin
      if (pend_valid[i] && (pend_rd[i] != '0) &&
          ((pend_rd[i] == bus.if_rs1) || (pend_rd[i] == bus.if_rs2))) begin
        hazard = 1'b1;
      end
    end
    hazard  = hazard & bus.if_valid & ~rst;
    ex_hold = (state == MUL) & ~rst;
    stall   = ex_hold | hazard;
    // While EX is held the stage is not emptied, so no NOP is injected.
    bubble  = hazard & ~ex_hold;
    issue   = bus.if_valid & ~stall;
  end

  assign bus.stall   = stall;
  assign bus.bubble  = bubble;
  assign bus.ex_hold = ex_hold;

  // Pending-write pipeline, FSM and stall statistics. While a multi-cycle op
  // holds EX its entry stays in slot 0, MEM receives bubbles and older
  // entries keep draining towards WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      pend_valid   <= '0;
      stall_cycles <= '0;
      for (int i = 0; i < 3; i++) begin
        pend_rd[i] <= '0;
      end
    end else begin
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CW'(1);
      end

      case (state)
        RUN, HAZ: begin
          pend_valid[0] <= issue & bus.if_we & (bus.if_rd != '0);
          pend_rd[0]    <= bus.if_rd;
          pend_valid[1] <= pend_valid[0];
          pend_rd[1]    <= pend_rd[0];
          pend_valid[2] <= pend_valid[1];
          pend_rd[2]    <= pend_rd[1];
          // A multi op leaving IF occupies EX for MUL_LAT-1 further cycles.
          if (issue && bus.if_multi && (MUL_LAT > 1)) begin
            state <= MUL;
            cnt   <= CNT_INIT;
          end else if (hazard) begin
            state <= HAZ;
          end else begin
            state <= RUN;
          end
        end

        MUL: begin
          pend_valid[1] <= 1'b0;
          pend_valid[2] <= pend_valid[1];
          pend_rd[2]    <= pend_rd[1];
          cnt           <= cnt - CNTW'(1);
          // Any hazard seen during MUL is re-evaluated once back in RUN.
          if (cnt == CNTW'(1)) begin
            state <= RUN;
          end
        end

        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl. Three instances share the same
//   issue stream: dut_a (WB bypass, 16-bit counter), dut_b (no WB bypass) and
//   dut_c (4-bit counter). Each driven cycle may push the hand-computed
//   response of one selected instance; a monitor pops and compares on the
//   falling edge.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       d_valid;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic [4:0] d_rd;
  logic       d_we;
  logic       d_multi;

  logic [15:0] cyc_a;
  logic [15:0] cyc_b;
  logic [3:0]  cyc_c;

  hazard_stall_ctrl_if #(.RW(5)) bus_a ();
  hazard_stall_ctrl_if #(.RW(5)) bus_b ();
  hazard_stall_ctrl_if #(.RW(5)) bus_c ();

  assign bus_a.if_valid = d_valid;
  assign bus_a.if_rs1   = d_rs1;
  assign bus_a.if_rs2   = d_rs2;
  assign bus_a.if_rd    = d_rd;
  assign bus_a.if_we    = d_we;
  assign bus_a.if_multi = d_multi;
  assign bus_b.if_valid = d_valid;
  assign bus_b.if_rs1   = d_rs1;
  assign bus_b.if_rs2   = d_rs2;
  assign bus_b.if_rd    = d_rd;
  assign bus_b.if_we    = d_we;
  assign bus_b.if_multi = d_multi;
  assign bus_c.if_valid = d_valid;
  assign bus_c.if_rs1   = d_rs1;
  assign bus_c.if_rs2   = d_rs2;
  assign bus_c.if_rd    = d_rd;
  assign bus_c.if_we    = d_we;
  assign bus_c.if_multi = d_multi;

  hazard_stall_ctrl #(.RW(5), .MUL_LAT(4), .WB_BYPASS(1), .CW(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .stall_cycles(cyc_a)
  );
  hazard_stall_ctrl #(.RW(5), .MUL_LAT(4), .WB_BYPASS(0), .CW(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .stall_cycles(cyc_b)
  );
  hazard_stall_ctrl #(.RW(5), .MUL_LAT(4), .WB_BYPASS(1), .CW(4)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .stall_cycles(cyc_c)
  );

  typedef struct {
    int   sel;
    int   step;
    logic s;
    logic b;
    logic h;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  // Drive one cycle of inputs just after the rising edge; sel<0 means the
  // cycle carries no expectation.
  task automatic applyStimulus(input int sel, input logic r, input logic v,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic m,
                               input logic es, input logic eb, input logic eh,
                               input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = r;
    d_valid = v;
    d_rs1   = rs1;
    d_rs2   = rs2;
    d_rd    = rd;
    d_we    = we;
    d_multi = m;
    step++;
    if (sel >= 0) begin
      e.sel  = sel;
      e.step = step;
      e.s    = es;
      e.b    = eb;
      e.h    = eh;
      e.cnt  = ec;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic s, b, h;
    int   c;
    case (e.sel)
      0: begin s = bus_a.stall; b = bus_a.bubble; h = bus_a.ex_hold; c = int'(cyc_a); end
      1: begin s = bus_b.stall; b = bus_b.bubble; h = bus_b.ex_hold; c = int'(cyc_b); end
      default: begin s = bus_c.stall; b = bus_c.bubble; h = bus_c.ex_hold; c = int'(cyc_c); end
    endcase
    n_cmp++;
    if ((s !== e.s) || (b !== e.b) || (h !== e.h) || (c != e.cnt)) begin
      n_bad++;
      $display("[TB] FAIL step%0d dut%0d: got stall=%0b bubble=%0b ex_hold=%0b cycles=%0d, expected stall=%0b bubble=%0b ex_hold=%0b cycles=%0d",
               e.step, e.sel, s, b, h, c, e.s, e.b, e.h, e.cnt);
    end
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the queued response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Stimulus: directed vectors (sel, rst, valid, rs1, rs2, rd, we, multi,
  // expected stall, bubble, ex_hold, stall_cycles).
  initial begin : stimulus
    int st;
    rst = 1'b1; d_valid = 1'b0; d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_we = 1'b0; d_multi = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with a would-be hazard on the inputs
    applyStimulus(0, 1, 1, 3, 0, 3, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 3, 0, 3, 1, 0, 0, 0, 0, 0);

    // RAW via rs1 then via rs2 (WB bypass: two stall cycles each)
    applyStimulus(0, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 1, 5, 0, 6, 1, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 1, 0, 6, 0, 0, 0, 1, 1, 0, 2);
    applyStimulus(0, 0, 1, 0, 6, 0, 0, 0, 1, 1, 0, 3);
    applyStimulus(0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);

    // Zero-register producer and non-writing producer
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 9, 9, 10, 1, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);

    // Multi op with an independent follower
    applyStimulus(0, 0, 1, 1, 2, 7, 1, 1, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 3, 4, 8, 1, 0, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 3, 4, 8, 1, 0, 1, 0, 1, 5);
    applyStimulus(0, 0, 1, 3, 4, 8, 1, 0, 1, 0, 1, 6);
    applyStimulus(0, 0, 1, 3, 4, 8, 1, 0, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);

    // Multi op with a dependent follower: hold, then two bubbles
    applyStimulus(0, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 7);
    applyStimulus(0, 0, 1, 0, 7, 11, 1, 0, 1, 0, 1, 7);
    applyStimulus(0, 0, 1, 0, 7, 11, 1, 0, 1, 0, 1, 8);
    applyStimulus(0, 0, 1, 0, 7, 11, 1, 0, 1, 0, 1, 9);
    applyStimulus(0, 0, 1, 0, 7, 11, 1, 0, 1, 1, 0, 10);
    applyStimulus(0, 0, 1, 0, 7, 11, 1, 0, 1, 1, 0, 11);
    applyStimulus(0, 0, 1, 0, 7, 11, 1, 0, 0, 0, 0, 12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);

    // Reset in the middle of a multi op
    applyStimulus(0, 0, 1, 0, 0, 12, 1, 1, 0, 0, 0, 12);
    applyStimulus(0, 0, 1, 3, 0, 13, 1, 0, 1, 0, 1, 12);
    applyStimulus(0, 1, 1, 3, 0, 13, 1, 0, 0, 0, 0, 13);
    applyStimulus(0, 0, 1, 3, 0, 13, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during a RAW stall
    applyStimulus(0, 0, 1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 14, 0, 15, 1, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 14, 0, 15, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 14, 0, 15, 1, 0, 0, 0, 0, 0);

    // RAW without WB bypass: three stall cycles
    applyStimulus(-1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 1);
    applyStimulus(1, 0, 1, 5, 0, 6, 1, 0, 1, 1, 0, 2);
    applyStimulus(1, 0, 1, 5, 0, 6, 1, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

    // Counter saturation: back-to-back multi ops, 3 stalls per 4 cycles
    applyStimulus(-1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 28; k++) begin
      st = k - (k + 3) / 4;
      if (st > 15) st = 15;
      applyStimulus(2, 0, 1, 0, 0, 0, 0, 1, (k % 4) != 0, 0, (k % 4) != 0, st);
    end
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15);

    for (int i = 0; (i < 20) && (sb.size() > 0); i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
